coretimer_apb_sequencer: RTL and testbench
==========================================

Name: coretimer_apb_sequencer

Overview:
- APB3-less (APB2, no PREADY) master that programs and services one CoreTimer instance (32-bit, active-high TIMINT) on its slave APB port.
- On a start request it writes Prescale, Load and Control. It then clears each timer interrupt, counts expirations and emits a tick pulse.
- Also supports stop and an on-demand TimerValue snapshot.
- Sits between the MIV subsystem control logic and the CoreTimer slave, replacing software-driven timer setup.

Parameters:
- WIDTH, 32, timer width; load_val width; must match the CoreTimer WIDTH.
- TICK_W, 16, width of the expiration counter tick_count.
- INT_ACTIVE_HIGH, 1, TIMINT polarity: 1 means asserted high, 0 means asserted low.

Ports:
- PCLK  in  1  clock; same clock as CoreTimer PCLK.
- PRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request: capture config and program timer.
- stop  in  1  one-cycle request: disable timer.
- snap  in  1  one-cycle request: read TimerValue.
- load_val  in  WIDTH  reload value, captured on accepted start.
- prescale  in  4  TimerPrescale code, captured on accepted start.
- oneshot  in  1  1 = one-shot mode (Control bit2), captured on accepted start.
- TIMINT  in  1  interrupt from CoreTimer.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  3  word address [4:2].
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- busy  out  1  high from accepted start until return to IDLE.
- tick  out  1  one-cycle pulse per serviced expiration.
- tick_count  out  TICK_W  count of expirations since last accepted start.
- snap_data  out  WIDTH  last TimerValue read.
- snap_valid  out  1  one-cycle pulse when snap_data updates.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values (async, PRESETn low):
  - State: IDLE.
  - Zero: all APB outputs, busy, tick, tick_count, snap_data, snap_valid, cfg_err.
  - Captured config: zero.
- Interface: one clock (PCLK); reset is asynchronous and active-low (PRESETn).
- APB transfer timing:
  - Every transfer is exactly 2 cycles: SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1).
  - PADDR, PWRITE and PWDATA are stable across both cycles.
  - Back-to-back transfers are allowed: the next SETUP may follow the ACCESS cycle directly.
  - PRDATA is sampled at the end of ACCESS.
- Register addresses (PADDR):
  - Load = 0, Value = 1, Control = 2, Prescale = 3, IntClr = 4.
- States and transitions:
  - IDLE:
    - start with load_val != 0: capture config, clear tick_count, busy=1, go to WR_PRE.
    - start with load_val == 0: cfg_err pulse; remain in IDLE.
    - stop and snap are ignored.
  - Configuration sequence: WR_PRE → WR_LOAD → WR_CTRL → RUN.
    - WR_PRE writes {28'b0, prescale}.
    - WR_LOAD writes load_val zero-extended to 32 bits.
    - WR_CTRL writes {29'b0, oneshot, 1'b1 (IntEn), 1'b1 (Enable)}.
    - The full configuration takes 6 cycles from start acceptance to RUN entry.
  - RUN:
    - Priority order per cycle: stop_pend, then TIMINT asserted, then snap_pend.
    - stop_pend: go to WR_STOP.
    - TIMINT asserted (TIMINT == INT_ACTIVE_HIGH): go to WR_ICLR.
    - snap_pend: go to RD_VAL.
  - WR_ICLR: writes IntClr (data 1).
    - In the ACCESS cycle: tick pulses and tick_count increments (wraps at 2^TICK_W-1 → 0).
    - Next state: IDLE if oneshot (busy drops), else RUN.
  - WR_STOP: writes Control = 0, then IDLE; busy drops the cycle after ACCESS.
  - RD_VAL: reads Value.
    - Cycle after ACCESS: snap_data = PRDATA[WIDTH-1:0], snap_valid pulses.
    - Then returns to RUN.
- Request latching:
  - stop and snap are latched into stop_pend and snap_pend while busy.
  - Pending flags clear when the corresponding transfer starts.
  - stop_pend also clears on return to IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - start with stop in the same IDLE cycle: start wins; stop is discarded.
- TIMINT sampling: only sampled in RUN. TIMINT remains asserted until the IntClr write, so no event is lost and no double count occurs.
- Reset mid-transfer: APB outputs drop immediately. CoreTimer is reset by the same PRESETn.

Test Plan:
- Reset → all outputs 0, PSEL=0. Start with load_val=0x10, prescale=0, oneshot=0 → writes observed in order: PADDR 3 data 0x0, PADDR 0 data 0x10, PADDR 2 data 0x3; each write 2 cycles, 6 cycles total.
- Periodic mode with TIMINT asserted three times → three IntClr writes (PADDR 4, data 1); tick pulses 3×; tick_count=3; busy stays 1.
- oneshot=1 → Control data 0x7; after first interrupt, IntClr write, then busy=0, tick_count=1.
- snap during RUN, PRDATA=0x0000_0ABC → Value read (PADDR 1, PWRITE=0); snap_data=0xABC with one snap_valid pulse. snap and TIMINT together → IntClr first, then read.
- stop asserted during WR_LOAD → configuration completes, then Control write 0x0, then busy=0. start with load_val=0 → cfg_err pulse, no APB activity.
- PRESETn asserted during the ACCESS cycle of WR_CTRL → PSEL/PENABLE=0 asynchronously; state IDLE; tick_count=0.

Source files
------------

// File: rtl/coretimer_apb_sequencer.sv
// APB2 master for one CoreTimer. It programs Prescale/Load/Control on start,
// clears and counts interrupts, and performs stop and TimerValue snapshot transfers.
module coretimer_apb_sequencer #(
   parameter int WIDTH           = 32,
   parameter int TICK_W          = 16,
   parameter bit INT_ACTIVE_HIGH = 1'b1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              start,
   input  logic              stop,
   input  logic              snap,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [3:0]        prescale,
   input  logic              oneshot,
   input  logic              TIMINT,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [2:0]        PADDR,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   output logic              busy,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic [WIDTH-1:0]  snap_data,
   output logic              snap_valid,
   output logic              cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_PRE, S_WR_LOAD, S_WR_CTRL, S_RUN, S_WR_ICLR, S_WR_STOP, S_RD_VAL
   } state_t;

   localparam logic [2:0] ADDR_LOAD  = 3'd0;
   localparam logic [2:0] ADDR_VALUE = 3'd1;
   localparam logic [2:0] ADDR_CTRL  = 3'd2;
   localparam logic [2:0] ADDR_PRE   = 3'd3;
   localparam logic [2:0] ADDR_ICLR  = 3'd4;

   state_t            state_q, state_d;
   logic              access_q, access_d;
   logic [WIDTH-1:0]  load_q, load_d;
   logic [3:0]        prescale_q, prescale_d;
   logic              oneshot_q, oneshot_d;
   logic              busy_q, busy_d;
   logic [TICK_W-1:0] tick_count_q, tick_count_d;
   logic [WIDTH-1:0]  snap_data_q, snap_data_d;
   logic              snap_valid_q, snap_valid_d;
   logic              cfg_err_q, cfg_err_d;
   logic              stop_pend_q, stop_pend_d;
   logic              snap_pend_q, snap_pend_d;
   logic              stop_clr, snap_clr, int_hit;

   assign int_hit = (TIMINT == INT_ACTIVE_HIGH);

   always_comb begin
      state_d      = state_q;
      access_d     = access_q;
      load_d       = load_q;
      prescale_d   = prescale_q;
      oneshot_d    = oneshot_q;
      busy_d       = busy_q;
      tick_count_d = tick_count_q;
      snap_data_d  = snap_data_q;
      snap_valid_d = 1'b0;
      cfg_err_d    = 1'b0;
      stop_clr     = 1'b0;
      snap_clr     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stop_clr = 1'b1;
            if (start) begin
               if (load_val != '0) begin
                  load_d       = load_val;
                  prescale_d   = prescale;
                  oneshot_d    = oneshot;
                  tick_count_d = '0;
                  busy_d       = 1'b1;
                  state_d      = S_WR_PRE;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (stop_pend_q) begin
               state_d  = S_WR_STOP;
               stop_clr = 1'b1;
            end else if (int_hit) begin
               state_d = S_WR_ICLR;
            end else if (snap_pend_q) begin
               state_d  = S_RD_VAL;
               snap_clr = 1'b1;
            end
         end
         default: begin
            // Every transfer state is a SETUP cycle followed by an ACCESS cycle.
            access_d = ~access_q;
            if (access_q) begin
               case (state_q)
                  S_WR_PRE:  state_d = S_WR_LOAD;
                  S_WR_LOAD: state_d = S_WR_CTRL;
                  S_WR_CTRL: state_d = S_RUN;
                  S_WR_ICLR: begin
                     tick_count_d = tick_count_q + TICK_W'(1);
                     if (oneshot_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                     end else begin
                        state_d = S_RUN;
                     end
                  end
                  S_WR_STOP: begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
                  S_RD_VAL: begin
                     snap_data_d  = PRDATA[WIDTH-1:0];
                     snap_valid_d = 1'b1;
                     state_d      = S_RUN;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase
      stop_pend_d = (stop_pend_q & ~stop_clr) | (busy_q & stop);
      snap_pend_d = (snap_pend_q & ~snap_clr) | (busy_q & snap);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= S_IDLE;
         access_q     <= 1'b0;
         load_q       <= '0;
         prescale_q   <= '0;
         oneshot_q    <= 1'b0;
         busy_q       <= 1'b0;
         tick_count_q <= '0;
         snap_data_q  <= '0;
         snap_valid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         stop_pend_q  <= 1'b0;
         snap_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         access_q     <= access_d;
         load_q       <= load_d;
         prescale_q   <= prescale_d;
         oneshot_q    <= oneshot_d;
         busy_q       <= busy_d;
         tick_count_q <= tick_count_d;
         snap_data_q  <= snap_data_d;
         snap_valid_q <= snap_valid_d;
         cfg_err_q    <= cfg_err_d;
         stop_pend_q  <= stop_pend_d;
         snap_pend_q  <= snap_pend_d;
      end
   end

   // APB outputs decode straight from the state flops so reset clears them at once.
   always_comb begin
      PSEL   = 1'b0;
      PWRITE = 1'b0;
      PADDR  = '0;
      PWDATA = '0;
      unique case (state_q)
         S_WR_PRE:  begin PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_PRE;   PWDATA = {28'b0, prescale_q}; end
         S_WR_LOAD: begin PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_LOAD;  PWDATA = 32'(load_q); end
         S_WR_CTRL: begin PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CTRL;  PWDATA = {29'b0, oneshot_q, 2'b11}; end
         S_WR_ICLR: begin PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_ICLR;  PWDATA = 32'd1; end
         S_WR_STOP: begin PSEL = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CTRL;  PWDATA = 32'd0; end
         S_RD_VAL:  begin PSEL = 1'b1; PWRITE = 1'b0; PADDR = ADDR_VALUE; PWDATA = 32'd0; end
         default: ;
      endcase
      PENABLE = PSEL & access_q;
   end

   assign busy       = busy_q;
   assign tick       = (state_q == S_WR_ICLR) & access_q;
   assign tick_count = tick_count_q;
   assign snap_data  = snap_data_q;
   assign snap_valid = snap_valid_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_coretimer_apb_sequencer.sv
// Directed bench for coretimer_apb_sequencer: stimulus pushes the expected APB
// transfer list; a negedge compare process checks every cycle against it.
module tb_coretimer_apb_sequencer;

   localparam int WIDTH  = 32;
   localparam int TICK_W = 16;

   logic              PCLK = 1'b0;
   logic              PRESETn;
   logic              start, stop, snap, oneshot, TIMINT;
   logic [WIDTH-1:0]  load_val;
   logic [3:0]        prescale;
   logic              PSEL, PENABLE, PWRITE;
   logic [2:0]        PADDR;
   logic [31:0]       PWDATA, PRDATA;
   logic              busy, tick, snap_valid, cfg_err;
   logic [TICK_W-1:0] tick_count;
   logic [WIDTH-1:0]  snap_data;

   coretimer_apb_sequencer #(.WIDTH(WIDTH), .TICK_W(TICK_W), .INT_ACTIVE_HIGH(1'b1)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .stop(stop), .snap(snap),
      .load_val(load_val), .prescale(prescale), .oneshot(oneshot), .TIMINT(TIMINT),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .busy(busy), .tick(tick), .tick_count(tick_count),
      .snap_data(snap_data), .snap_valid(snap_valid), .cfg_err(cfg_err)
   );

   always #5 PCLK = ~PCLK;

   // Written only by the stimulus process.
   logic [2:0]        exp_addr [0:63];
   logic              exp_wr   [0:63];
   logic [31:0]       exp_data [0:63];
   int                exp_n = 0;
   int                epoch = 0;
   logic              exp_busy = 1'b0;
   logic              exp_cfg_err = 1'b0;
   logic              pin_tc_en = 1'b0;
   logic [TICK_W-1:0] pin_tc_val = '0;
   logic              pin_snap_en = 1'b0;
   logic [31:0]       pin_snap_val = '0;
   logic              pin_done_en = 1'b0;

   // Written only by the compare process.
   int                tests_run = 0;
   int                tests_failed = 0;
   int                rd_idx = 0;
   int                seen_epoch = 0;
   logic              in_setup = 1'b0;
   logic [2:0]        s_addr = '0;
   logic              s_wr = 1'b0;
   logic [31:0]       s_data = '0;
   logic              prev_rd = 1'b0;
   logic [31:0]       rd_capt = '0;
   logic              clr_pend = 1'b0;
   logic              exp_tick = 1'b0;
   logic [TICK_W-1:0] mdl_count = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: transfers must appear in the pushed order; each IntClr write is one
   // expiration (tick during its ACCESS, count afterwards); each read yields snap data.
   always @(negedge PCLK) begin
      if (!PRESETn) begin
         checkOutput("rst_psel", 32'(PSEL), 32'd0);
         checkOutput("rst_penable", 32'(PENABLE), 32'd0);
         checkOutput("rst_pwrite", 32'(PWRITE), 32'd0);
         checkOutput("rst_paddr", 32'(PADDR), 32'd0);
         checkOutput("rst_pwdata", PWDATA, 32'd0);
         checkOutput("rst_busy", 32'(busy), 32'd0);
         checkOutput("rst_tick", 32'(tick), 32'd0);
         checkOutput("rst_tick_count", 32'(tick_count), 32'd0);
         checkOutput("rst_snap_data", 32'(snap_data), 32'd0);
         checkOutput("rst_snap_valid", 32'(snap_valid), 32'd0);
         checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
         mdl_count  = '0;
         rd_idx     = exp_n;
         in_setup   = 1'b0;
         prev_rd    = 1'b0;
         clr_pend   = 1'b0;
         seen_epoch = epoch;
      end else begin
         if (clr_pend) mdl_count = '0;
         clr_pend = 1'b0;
         checkOutput("snap_valid", 32'(snap_valid), 32'(prev_rd));
         if (prev_rd) checkOutput("snap_data", 32'(snap_data), rd_capt);
         prev_rd = 1'b0;
         checkOutput("tick_count", 32'(tick_count), 32'(mdl_count));
         checkOutput("busy", 32'(busy), 32'(exp_busy));
         checkOutput("cfg_err", 32'(cfg_err), 32'(exp_cfg_err));
         if (pin_tc_en) begin
            checkOutput("pin_tick_count", 32'(tick_count), 32'(pin_tc_val));
            checkOutput("pin_model_count", 32'(mdl_count), 32'(pin_tc_val));
         end
         if (pin_snap_en) checkOutput("pin_snap_data", 32'(snap_data), pin_snap_val);
         exp_tick = 1'b0;
         if (PSEL && !PENABLE) begin
            checkOutput("setup_twice", 32'(in_setup), 32'd0);
            s_addr   = PADDR;
            s_wr     = PWRITE;
            s_data   = PWDATA;
            in_setup = 1'b1;
         end else if (PSEL && PENABLE) begin
            checkOutput("access_without_setup", 32'(in_setup), 32'd1);
            checkOutput("paddr_stable", 32'(PADDR), 32'(s_addr));
            checkOutput("pwrite_stable", 32'(PWRITE), 32'(s_wr));
            checkOutput("pwdata_stable", PWDATA, s_data);
            if (rd_idx < exp_n) begin
               checkOutput("xfer_addr", 32'(PADDR), 32'(exp_addr[rd_idx]));
               checkOutput("xfer_write", 32'(PWRITE), 32'(exp_wr[rd_idx]));
               if (exp_wr[rd_idx]) checkOutput("xfer_wdata", PWDATA, exp_data[rd_idx]);
               exp_tick = exp_wr[rd_idx] && (exp_addr[rd_idx] == 3'd4);
               if (!exp_wr[rd_idx]) begin
                  prev_rd = 1'b1;
                  rd_capt = PRDATA;
               end
               rd_idx++;
            end else begin
               checkOutput("unexpected_xfer", 32'(PSEL), 32'd0);
            end
            in_setup = 1'b0;
         end else begin
            checkOutput("setup_dropped", 32'(in_setup), 32'd0);
            in_setup = 1'b0;
            if (pin_done_en) begin
               checkOutput("xfers_done", 32'(rd_idx), 32'(exp_n));
            end
         end
         if (pin_done_en && PSEL) checkOutput("apb_idle", 32'(PSEL), 32'd0);
         checkOutput("tick", 32'(tick), 32'(exp_tick));
         if (exp_tick) mdl_count = mdl_count + TICK_W'(1);
         if (epoch != seen_epoch) begin
            clr_pend   = 1'b1;
            seen_epoch = epoch;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic expectXfer(input logic [2:0] a, input logic w, input logic [31:0] d);
      exp_addr[exp_n] = a;
      exp_wr[exp_n]   = w;
      exp_data[exp_n] = d;
      exp_n++;
   endtask

   // One-cycle start; returns one cycle after acceptance (two after a reject).
   task automatic applyStimulus(input logic [31:0] ld, input logic [3:0] pre, input logic one,
                                input logic stp, input logic accepted);
      start    = 1'b1;
      stop     = stp;
      load_val = ld;
      prescale = pre;
      oneshot  = one;
      if (accepted) epoch++;
      step(1);
      start = 1'b0;
      stop  = 1'b0;
      if (accepted) begin
         exp_busy = 1'b1;
      end else begin
         exp_cfg_err = 1'b1;
         step(1);
         exp_cfg_err = 1'b0;
      end
   endtask

   task automatic fireInt();
      TIMINT = 1'b1;
      expectXfer(3'd4, 1'b1, 32'd1);
      step(3);
      TIMINT = 1'b0;
      step(1);
   endtask

   task automatic pinTickCount(input logic [TICK_W-1:0] v);
      pin_tc_en  = 1'b1;
      pin_tc_val = v;
      step(1);
      pin_tc_en = 1'b0;
   endtask

   task automatic pinSnap(input logic [31:0] v);
      pin_snap_en  = 1'b1;
      pin_snap_val = v;
      step(1);
      pin_snap_en = 1'b0;
   endtask

   task automatic pinDone();
      pin_done_en = 1'b1;
      step(1);
      pin_done_en = 1'b0;
   endtask

   initial begin
      PRESETn  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      snap     = 1'b0;
      oneshot  = 1'b0;
      TIMINT   = 1'b0;
      load_val = '0;
      prescale = '0;
      PRDATA   = 32'h0000_0ABC;
      step(2);
      PRESETn = 1'b1;
      step(2);

      // Periodic: program, three interrupts, snapshot, snap+interrupt, stop.
      expectXfer(3'd3, 1'b1, 32'h0);
      expectXfer(3'd0, 1'b1, 32'h10);
      expectXfer(3'd2, 1'b1, 32'h3);
      applyStimulus(32'h10, 4'd0, 1'b0, 1'b0, 1'b1);
      step(6);
      pinDone();
      fireInt();
      fireInt();
      fireInt();
      pinTickCount(16'd3);
      expectXfer(3'd1, 1'b0, 32'h0);
      snap = 1'b1;
      step(1);
      snap = 1'b0;
      step(3);
      pinSnap(32'h0000_0ABC);
      PRDATA = 32'h1234_5678;
      TIMINT = 1'b1;
      snap   = 1'b1;
      expectXfer(3'd4, 1'b1, 32'd1);
      expectXfer(3'd1, 1'b0, 32'h0);
      step(1);
      snap = 1'b0;
      step(2);
      TIMINT = 1'b0;
      step(3);
      pinSnap(32'h1234_5678);
      pinTickCount(16'd4);
      expectXfer(3'd2, 1'b1, 32'h0);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(3);
      exp_busy = 1'b0;
      step(2);

      // One-shot: Control 0x7, single interrupt ends the run.
      expectXfer(3'd3, 1'b1, 32'h5);
      expectXfer(3'd0, 1'b1, 32'h20);
      expectXfer(3'd2, 1'b1, 32'h7);
      applyStimulus(32'h20, 4'd5, 1'b1, 1'b0, 1'b1);
      pinTickCount(16'd0);
      step(5);
      TIMINT = 1'b1;
      expectXfer(3'd4, 1'b1, 32'd1);
      step(3);
      exp_busy = 1'b0;
      TIMINT   = 1'b0;
      pinTickCount(16'd1);
      step(2);

      // Idle: stop/snap ignored, zero load rejected.
      snap = 1'b1;
      stop = 1'b1;
      step(1);
      snap = 1'b0;
      stop = 1'b0;
      step(2);
      applyStimulus(32'h0, 4'd3, 1'b0, 1'b0, 1'b0);
      step(2);

      // Stop during WR_LOAD: configuration completes, then Control=0.
      expectXfer(3'd3, 1'b1, 32'h1);
      expectXfer(3'd0, 1'b1, 32'h30);
      expectXfer(3'd2, 1'b1, 32'h3);
      expectXfer(3'd2, 1'b1, 32'h0);
      applyStimulus(32'h30, 4'd1, 1'b0, 1'b0, 1'b1);
      step(2);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(6);
      exp_busy = 1'b0;
      step(2);

      // Start with stop in the same cycle, then starts while busy are ignored.
      expectXfer(3'd3, 1'b1, 32'h2);
      expectXfer(3'd0, 1'b1, 32'h40);
      expectXfer(3'd2, 1'b1, 32'h3);
      applyStimulus(32'h40, 4'd2, 1'b0, 1'b1, 1'b1);
      step(1);
      start    = 1'b1;
      load_val = 32'h99;
      step(1);
      load_val = 32'h0;
      step(1);
      start = 1'b0;
      step(3);
      step(3);
      expectXfer(3'd2, 1'b1, 32'h0);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(3);
      exp_busy = 1'b0;
      step(2);

      // Reset during the ACCESS cycle of WR_CTRL.
      expectXfer(3'd3, 1'b1, 32'h0);
      expectXfer(3'd0, 1'b1, 32'h50);
      expectXfer(3'd2, 1'b1, 32'h3);
      applyStimulus(32'h50, 4'd0, 1'b0, 1'b0, 1'b1);
      step(5);
      PRESETn  = 1'b0;
      exp_busy = 1'b0;
      step(1);
      PRESETn = 1'b1;
      step(2);
      pinTickCount(16'd0);
      pinDone();
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
